multififo_wn_rn: RTL
====================

Name: multififo_wn_rn

Overview:
- Parametrised multi-lane FIFO: accepts 0..NW entries per cycle on the write side and retires 0..NR entries per cycle on the read side.
- Read side presents a look-ahead window of the NR oldest entries.
- Adds selectable partial-grant mode, per-lane valid mask, granted-count outputs and sticky error flags.
- Sits between variable-rate producers and consumers, e.g. packers/unpackers and multi-issue queues.

Parameters:
- WIDTH, 32, bits per entry.
- DEPTH, 8, number of entries; any integer 2..65535, not required to be a power of two; must be >= max(NW,NR).
- NW, 1, write lanes per cycle.
- NR, 8, read lanes per cycle.
- PARTIAL, 0, 0 = all-or-nothing grant; 1 = grant as many as fit/exist.
- Derived (localparams): WP = $clog2(DEPTH); CW = $clog2(NW+1); CR = $clog2(NR+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- softreset  in  1  synchronous clear of pointers, count and error flags.
- writes  in  CW  entries offered this cycle; lane 0 is the oldest.
- din  in  WIDTH*NW  lane k at din[WIDTH*(k+1)-1:WIDTH*k].
- reads  in  CR  entries to retire this cycle.
- dout  out  WIDTH*NR  lane i = entry at (rptr+i) mod DEPTH.
- dvalid  out  NR  dvalid[i] = (i < count).
- wgrant  out  CW  entries actually written this cycle (combinational).
- rgrant  out  CR  entries actually retired this cycle (combinational).
- count  out  16  occupied entries (registered).
- frees  out  16  DEPTH - count.
- err_wr  out  1  sticky: any write rejected or truncated, or writes > NW.
- err_rd  out  1  sticky: any read rejected or truncated, or reads > NR.

Behaviour:
- Reset (rst_n low, asynchronous): wptr = 0, rptr = 0, count = 0, err_wr = 0, err_rd = 0. Storage is cleared to 0, so all dout lanes read 0; dvalid = 0; frees = DEPTH.
- softreset (sync, while rst_n high): same clears as reset except storage, which is left as is. softreset has priority over any write/read in that cycle; wgrant and rgrant are forced to 0 that cycle.
- Illegal requests: writes > NW gives wgrant = 0 and sets err_wr. reads > NR gives rgrant = 0 and sets err_rd.
- Write grant, PARTIAL=0: wgrant = (writes <= frees) ? writes : 0.
- Write grant, PARTIAL=1: wgrant = min(writes, frees).
- err_wr also sets whenever 0 < wgrant < writes, or when writes > 0 and wgrant = 0.
- Read grant: computed the same way against count. err_rd follows the same truncation/rejection rules.
- Space and data are judged on start-of-cycle state only:
  - a same-cycle read does not free space for a same-cycle write;
  - a same-cycle write is not readable in that cycle;
  - no bypass path.
- Write: lanes 0..wgrant-1 are stored at (wptr+k) mod DEPTH; wptr <= (wptr+wgrant) mod DEPTH.
- Read: rptr <= (rptr+rgrant) mod DEPTH.
- Count: count <= count + wgrant - rgrant.
- Modulo arithmetic: performed with one conditional subtract on a WP+1 bit sum; valid because NW, NR <= DEPTH.
- Latency: written data appears on dout the cycle after the write edge.
- dout/dvalid are combinational from rptr and storage. Lanes with dvalid = 0 carry stale data and must be ignored.
- Full (count = DEPTH): writes > 0 gives wgrant = 0 and sets err_wr. A simultaneous read still proceeds.
- Empty: reads > 0 gives rgrant = 0 and sets err_rd.
- Error flags are sticky until rst_n or softreset.

Test Plan:
- Defaults (DEPTH=8, NW=1, NR=8, PARTIAL=0): write 8 single entries 0xA0..0xA7 -> count=8, frees=0, dvalid=0xFF, dout lane i = 0xA0+i; 9th write -> wgrant=0, err_wr=1, count stays 8.
- Defaults, FIFO holding 3 entries: reads=4 -> rgrant=0, err_rd=1, rptr unchanged; then reads=3 -> rgrant=3, count=0, dvalid=0x00.
- Wrap, DEPTH=5, NW=2, NR=2: write pairs until full, read 2, write 2, across 10 cycles -> dout order matches write order across the 5->0 wrap; count never exceeds 5.
- PARTIAL=1, DEPTH=6, NW=4, count=4: writes=4 -> wgrant=2, only lanes 0-1 stored, count=6, err_wr=1.
- Simultaneous ops, defaults, count=8 (full): writes=1 with reads=2 -> wgrant=0, rgrant=2, count=6. Same cycle with count=4 -> count=3.
- softreset with writes=1 and reads=1 asserted, count=5, err_rd=1 -> next cycle count=0, err_rd=0, wgrant=0 and rgrant=0 during that cycle. Then assert rst_n low mid-stream -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multififo_wn_rn.sv
// multififo_wn_rn: multi-lane FIFO, 0..NW writes and 0..NR reads per cycle.
//   clk, rst_n (async, active low), softreset (sync clear of pointers/count/errors)
//   writes/din   : entries offered this cycle, lane 0 oldest
//   reads        : entries to retire this cycle
//   dout/dvalid  : look-ahead window of the NR oldest entries
//   wgrant/rgrant: entries actually written/retired this cycle
//   count/frees  : occupancy and free space
//   err_wr/err_rd: sticky rejected/truncated/illegal request flags
module multififo_wn_rn #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NW      = 1,
  parameter int unsigned NR      = 8,
  parameter int unsigned PARTIAL = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        softreset,
  input  logic [$clog2(NW+1)-1:0]     writes,
  input  logic [WIDTH*NW-1:0]         din,
  input  logic [$clog2(NR+1)-1:0]     reads,
  output logic [WIDTH*NR-1:0]         dout,
  output logic [NR-1:0]               dvalid,
  output logic [$clog2(NW+1)-1:0]     wgrant,
  output logic [$clog2(NR+1)-1:0]     rgrant,
  output logic [15:0]                 count,
  output logic [15:0]                 frees,
  output logic                        err_wr,
  output logic                        err_rd
);

  localparam int unsigned WP = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(NW+1);
  localparam int unsigned CR = $clog2(NR+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WP-1:0]    wptr;
  logic [WP-1:0]    rptr;
  logic             wr_bad;
  logic             rd_bad;

  // base < DEPTH and inc <= DEPTH, so a single conditional subtract wraps.
  function automatic logic [WP-1:0] wrap_add(input logic [WP-1:0] base, input logic [WP:0] inc);
    logic [WP:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= (WP+1)'(DEPTH))
      sum = sum - (WP+1)'(DEPTH);
    return sum[WP-1:0];
  endfunction

  assign frees = 16'(DEPTH) - count;

  // Grants judged on start-of-cycle count/frees only; no read-frees-write bypass.
  always_comb begin
    wgrant = '0;
    rgrant = '0;
    if (!softreset) begin
      if (32'(writes) <= NW) begin
        if (32'(writes) <= 32'(frees))
          wgrant = writes;
        else if (PARTIAL != 0)
          wgrant = CW'(frees);
      end
      if (32'(reads) <= NR) begin
        if (32'(reads) <= 32'(count))
          rgrant = reads;
        else if (PARTIAL != 0)
          rgrant = CR'(count);
      end
    end
    // Any nonzero request not fully granted covers illegal, rejected and truncated cases.
    wr_bad = !softreset && (writes != '0) && (wgrant != writes);
    rd_bad = !softreset && (reads  != '0) && (rgrant != reads);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      err_wr <= 1'b0;
      err_rd <= 1'b0;
    end else if (softreset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      err_wr <= 1'b0;
      err_rd <= 1'b0;
    end else begin
      wptr   <= wrap_add(wptr, (WP+1)'(wgrant));
      rptr   <= wrap_add(rptr, (WP+1)'(rgrant));
      count  <= count + 16'(wgrant) - 16'(rgrant);
      err_wr <= err_wr | wr_bad;
      err_rd <= err_rd | rd_bad;
    end
  end

  // wgrant is already zero during softreset, so storage is left untouched then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < NW; k++)
        if (32'(wgrant) > k)
          mem[wrap_add(wptr, (WP+1)'(k))] <= din[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    dout   = '0;
    dvalid = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      dout[i*WIDTH +: WIDTH] = mem[wrap_add(rptr, (WP+1)'(i))];
      dvalid[i]              = (32'(count) > i);
    end
  end

endmodule
